fb_wr_arbiter: RTL and testbench
================================

# fb_wr_arbiter

Arbitrates the single write port of the shared frame-buffer BRAM between the two camera capture paths. Each capture path pushes pixel writes (local region index plus RGB444 data) into a small per-camera holding buffer. A round-robin scheduler drains both buffers into BRAM port A at up to one write per `clk` cycle, adding each camera's region base address. The user display mode, which selects which cameras are live, takes effect per camera only at that camera's frame start, so a frame is never half-written.

## Interface
Parameters:
- `ADDR_W`, 20, BRAM address width.
- `DATA_W`, 12, pixel width (RGB444).
- `REGION_PIXELS`, 76800, pixels per camera region (320x240).
- `CAM0_BASE`, 0, region base address for camera 0.
- `CAM1_BASE`, 76800, region base address for camera 1.

Ports:
- `clk`  in  1  system clock (100 MHz); the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode_sel`  in  2  requested mode: 00 both, 01 cam0 only, 10 cam1 only, 11 freeze.
- `sof`  in  2  per-camera start-of-frame pulse, one `clk` wide, already synchronised to `clk`.
- `req_valid`  in  2  per-camera write request.
- `req_ready`  out  2  per-camera holding buffer not full.
- `req_addr`  in  2×ADDR_W  per-camera local pixel index.
- `req_data`  in  2×DATA_W  per-camera pixel.
- `bram_we`  out  1  BRAM port A write enable.
- `bram_addr`  out  ADDR_W  BRAM port A address.
- `bram_din`  out  DATA_W  BRAM port A data.
- `grant`  out  2  one-hot: camera whose write is on the port this cycle.
- `cam_live`  out  2  per-camera latched enable.
- `drop_cnt0`, `drop_cnt1`  out  16  per-camera dropped-write counters.

## Operation
- Each camera has a 2-entry FIFO. `req_ready[i] = (count_i != 2)`.
  - A push occurs when `req_valid[i] && req_ready[i] && cam_live[i]`.
  - There is no push-through when the FIFO is full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle on a 1-entry FIFO leave the count unchanged.
- Writes that are not accepted are dropped and never retried. The capture path cannot stall.
  - A drop is counted when `req_valid[i] && cam_live[i]` and either `!req_ready[i]` or `req_addr[i] >= REGION_PIXELS`.
  - Out-of-range addresses are never pushed.
- A non-live camera has all requests discarded silently. Its drop counter does not increment.
- Mode latch: on `sof[i]`, `cam_live[i]` loads the mode bit for camera i.
  - Camera 0 is live for modes 00/01; camera 1 for modes 00/10. Mode 11 clears both.
  - Between `sof` pulses, `cam_live` holds regardless of `mode_sel`.
  - A request in the same cycle as `sof[i]` uses the new value.
- Scheduler: a `last` pointer records the last camera granted.
  - If both FIFO heads are valid, grant `!last`. If one is valid, grant it. If none, idle.
  - `last` updates only on a grant.
- Output: on a grant, the registered outputs load `bram_we=1`, `bram_addr = head_addr + CAMi_BASE` (mod 2^ADDR_W), and `bram_din = head_data`. The head is popped in the same cycle.
- The FIFO is not flushed on a mode change. Entries already accepted are always written.

## Timing
- Reset values:
  - All outputs 0, except `req_ready` = 2'b11.
  - `cam_live` = 2'b00, so nothing is written until the first `sof`.
  - `last` = 1, so camera 0 wins the first contention.
  - FIFOs empty; counters 0.
- Latency: a push accepted at edge N reaches the arbitration head during cycle N+1. `bram_we`/`grant` are high for the cycle after edge N+2 when uncontended.
- Throughput: one BRAM write per cycle total. With sustained contention, the cameras alternate and each gets every other cycle.
- `bram_we` drops to 0 in the cycle after the last grant. `grant` is 0 whenever `bram_we` is 0.
- Reset asserted mid-operation clears the FIFOs immediately. Buffered pixels are lost; the next `sof` re-arms the cameras.

## Configuration
- `FB_ARB_DROP_CNT_EN` defined: `drop_cnt0`/`drop_cnt1` count drops as above, saturating at 16'hFFFF. They clear only on reset.
- Undefined: the counters and their logic are removed, both outputs are tied to 0, and drop behaviour is otherwise unchanged.

## Structure
- Package `fb_arb_pkg`:
  - mode encodings `MODE_BOTH`, `MODE_CAM0`, `MODE_CAM1`, `MODE_FREEZE`
  - default `REGION_PIXELS`, `CAM1_BASE`
  - counter width `DROP_CNT_W = 16`
- Sub-module `wr_skid_fifo`: 2-entry FIFO holding {addr, data}, with push/pop/count. It is instantiated once per camera.
- The scheduler, mode latch and counters live in the top of `fb_wr_arbiter`.

## Test plan
- Reset release, `mode_sel=00`, `sof=11`, a single cam0 write with addr 5 and data 12'hABC → `bram_we` high 2 edges later with addr 5, din ABC, `grant=01`.
- Both cameras push every cycle, cam1 at addr 0 → grants alternate 01,10,01…, cam0 first. Cam1 writes land at 76800. Each FIFO fills, and under `FB_ARB_DROP_CNT_EN` each drop counter increments on every other push.
- `mode_sel` switches 00→01 mid-frame → cam1 keeps writing until its next `sof[1]`, then its requests are discarded, `drop_cnt1` is unchanged and `cam_live=01`.
- Cam0 addr 76800 (out of range) → no write, `drop_cnt0` +1 (0 when the macro is undefined).
- Reset asserted with both FIFOs full → outputs 0 at once, and no writes until the next `sof`.
- Drive 70000 overflow drops → the counter saturates at FFFF.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared constants for the frame-buffer write arbiter.
// Holds the display-mode encodings, default region geometry and the
// drop-counter width, plus the mode-to-camera enable decode.
package fb_arb_pkg;

   localparam logic [1:0] MODE_BOTH   = 2'b00;
   localparam logic [1:0] MODE_CAM0   = 2'b01;
   localparam logic [1:0] MODE_CAM1   = 2'b10;
   localparam logic [1:0] MODE_FREEZE = 2'b11;

   localparam int DEF_REGION_PIXELS = 76800;
   localparam int DEF_CAM1_BASE     = 76800;

   localparam int DROP_CNT_W = 16;

   // Whether camera `cam` is enabled by display mode `mode`.
   function automatic logic mode_live(input logic [1:0] mode, input logic cam);
      logic live;
      case (mode)
         MODE_BOTH:   live = 1'b1;
         MODE_CAM0:   live = ~cam;
         MODE_CAM1:   live = cam;
         MODE_FREEZE: live = 1'b0;
         default:     live = 1'b0;
      endcase
      return live;
   endfunction

endpackage

// File: rtl/fb_wr_arbiter_skid_fifo.sv
// wr_skid_fifo: 2-entry holding buffer of {addr, data} for one camera.
// An entry is written at the push edge but only presented as a valid head
// one cycle later, which gives the scheduler a full cycle of settled data.
// count reflects occupancy immediately and drives the not-full indication.
module wr_skid_fifo
   import fb_arb_pkg::*;
#(
   parameter int AW = 20,
   parameter int DW = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          head_valid,
   output logic [1:0]    count
);

   logic [AW+DW-1:0] ent0_q, ent0_d;
   logic [AW+DW-1:0] ent1_q, ent1_d;
   logic [1:0]       count_q, count_d;
   logic             ripe_q, ripe_d;
   logic             push_ok, pop_ok;

   // Shift-style storage: entry 0 is always the head.
   always_comb begin
      push_ok = push && (count_q != 2'd2);
      pop_ok  = pop && ripe_q;
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      count_d = count_q;
      if (pop_ok) begin
         ent0_d  = ent1_q;
         count_d = count_d - 2'd1;
      end
      if (push_ok) begin
         if (count_d == 2'd0) ent0_d = {wr_addr, wr_data};
         else                 ent1_d = {wr_addr, wr_data};
         count_d = count_d + 2'd1;
      end
      // A head that arrived on this very edge is not yet presentable.
      if (count_d == 2'd0)
         ripe_d = 1'b0;
      else if (push_ok && ((count_q == 2'd0) || ((count_q == 2'd1) && pop_ok)))
         ripe_d = 1'b0;
      else
         ripe_d = 1'b1;
   end

   // Storage and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0_q  <= '0;
         ent1_q  <= '0;
         count_q <= 2'd0;
         ripe_q  <= 1'b0;
      end else begin
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         count_q <= count_d;
         ripe_q  <= ripe_d;
      end
   end

   assign rd_addr    = ent0_q[AW+DW-1:DW];
   assign rd_data    = ent0_q[DW-1:0];
   assign head_valid = ripe_q;
   assign count      = count_q;

endmodule

// File: rtl/fb_wr_arbiter.sv
// fb_wr_arbiter: shares BRAM write port A between two camera capture paths.
// Per-camera 2-entry buffers are drained round-robin, one write per cycle,
// with each camera's region base added to its local pixel index. The display
// mode is latched per camera at that camera's start of frame.
// Optional feature macro: FB_ARB_DROP_CNT_EN enables the saturating
// per-camera dropped-write counters; otherwise they read as zero.
module fb_wr_arbiter
   import fb_arb_pkg::*;
#(
   parameter int ADDR_W        = 20,
   parameter int DATA_W        = 12,
   parameter int REGION_PIXELS = DEF_REGION_PIXELS,
   parameter int CAM0_BASE     = 0,
   parameter int CAM1_BASE     = DEF_CAM1_BASE
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              mode_sel,
   input  logic [1:0]              sof,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [2*ADDR_W-1:0]     req_addr,
   input  logic [2*DATA_W-1:0]     req_data,
   output logic                    bram_we,
   output logic [ADDR_W-1:0]       bram_addr,
   output logic [DATA_W-1:0]       bram_din,
   output logic [1:0]              grant,
   output logic [1:0]              cam_live,
   output logic [DROP_CNT_W-1:0]   drop_cnt0,
   output logic [DROP_CNT_W-1:0]   drop_cnt1
);

   localparam logic [ADDR_W-1:0] REGION_LIM = ADDR_W'(REGION_PIXELS);
   localparam logic [ADDR_W-1:0] BASE0      = ADDR_W'(CAM0_BASE);
   localparam logic [ADDR_W-1:0] BASE1      = ADDR_W'(CAM1_BASE);

   logic [1:0]        cam_live_q, cam_live_d;
   logic [1:0]        fifo_push, fifo_pop, fifo_ready, head_valid, in_range;
   logic [1:0]        fifo_count [2];
   logic [ADDR_W-1:0] in_addr    [2];
   logic [ADDR_W-1:0] head_addr  [2];
   logic [DATA_W-1:0] in_data    [2];
   logic [DATA_W-1:0] head_data  [2];
   logic              last_q, last_d;
   logic              gnt_any, gnt_sel;
   logic              bram_we_q, bram_we_d;
   logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
   logic [DATA_W-1:0] bram_din_q, bram_din_d;
   logic [1:0]        grant_q, grant_d;

   for (genvar i = 0; i < 2; i++) begin : g_cam
      assign in_addr[i]    = req_addr[i*ADDR_W +: ADDR_W];
      assign in_data[i]    = req_data[i*DATA_W +: DATA_W];
      assign fifo_ready[i] = (fifo_count[i] != 2'd2);

      wr_skid_fifo #(
         .AW (ADDR_W),
         .DW (DATA_W)
      ) u_fifo (
         .clk        (clk),
         .rst_n      (rst_n),
         .push       (fifo_push[i]),
         .pop        (fifo_pop[i]),
         .wr_addr    (in_addr[i]),
         .wr_data    (in_data[i]),
         .rd_addr    (head_addr[i]),
         .rd_data    (head_data[i]),
         .head_valid (head_valid[i]),
         .count      (fifo_count[i])
      );
   end

   // Mode latch: a request coinciding with sof already sees the new enable.
   always_comb begin
      cam_live_d = cam_live_q;
      for (int i = 0; i < 2; i++) begin
         if (sof[i]) cam_live_d[i] = mode_live(mode_sel, 1'(i));
      end
   end

   // Accept only in-range requests from live cameras into a non-full buffer.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         in_range[i]  = (in_addr[i] < REGION_LIM);
         fifo_push[i] = req_valid[i] && fifo_ready[i] && cam_live_d[i] && in_range[i];
      end
   end

   // Round-robin pick between buffer heads; registered port outputs follow.
   always_comb begin
      gnt_any = 1'b0;
      gnt_sel = 1'b0;
      if (head_valid[0] && head_valid[1]) begin
         gnt_any = 1'b1;
         gnt_sel = ~last_q;
      end else if (head_valid[0]) begin
         gnt_any = 1'b1;
         gnt_sel = 1'b0;
      end else if (head_valid[1]) begin
         gnt_any = 1'b1;
         gnt_sel = 1'b1;
      end
      fifo_pop = 2'b00;
      if (gnt_any) fifo_pop[gnt_sel] = 1'b1;
      last_d      = gnt_any ? gnt_sel : last_q;
      bram_we_d   = gnt_any;
      grant_d     = fifo_pop;
      bram_addr_d = bram_addr_q;
      bram_din_d  = bram_din_q;
      if (gnt_any) begin
         bram_addr_d = head_addr[gnt_sel] + (gnt_sel ? BASE1 : BASE0);
         bram_din_d  = head_data[gnt_sel];
      end
   end

   // Scheduler, mode latch and BRAM port registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cam_live_q  <= 2'b00;
         last_q      <= 1'b1;
         bram_we_q   <= 1'b0;
         bram_addr_q <= '0;
         bram_din_q  <= '0;
         grant_q     <= 2'b00;
      end else begin
         cam_live_q  <= cam_live_d;
         last_q      <= last_d;
         bram_we_q   <= bram_we_d;
         bram_addr_q <= bram_addr_d;
         bram_din_q  <= bram_din_d;
         grant_q     <= grant_d;
      end
   end

   assign req_ready = fifo_ready;
   assign cam_live  = cam_live_q;
   assign bram_we   = bram_we_q;
   assign bram_addr = bram_addr_q;
   assign bram_din  = bram_din_q;
   assign grant     = grant_q;

`ifdef FB_ARB_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt_q [2];
   logic [DROP_CNT_W-1:0] drop_cnt_d [2];
   logic [1:0]            drop_evt;

   // A live camera loses a write when its buffer is full or the index is out of range.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         drop_evt[i]   = req_valid[i] && cam_live_d[i] && (!fifo_ready[i] || !in_range[i]);
         drop_cnt_d[i] = drop_cnt_q[i];
         if (drop_evt[i] && (drop_cnt_q[i] != '1))
            drop_cnt_d[i] = drop_cnt_q[i] + DROP_CNT_W'(1);
      end
   end

   // Saturating drop counters, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) drop_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) drop_cnt_q[i] <= drop_cnt_d[i];
      end
   end

   assign drop_cnt0 = drop_cnt_q[0];
   assign drop_cnt1 = drop_cnt_q[1];
`else
   assign drop_cnt0 = '0;
   assign drop_cnt1 = '0;
`endif

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// Bench for fb_wr_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fb_wr_arbiter;

   localparam int AW     = 20;
   localparam int DW     = 12;
   localparam int REGION = 76800;
   localparam int BASE1  = 76800;
`ifdef FB_ARB_DROP_CNT_EN
   localparam int DROP_INC = 1;
`else
   localparam int DROP_INC = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [1:0]    mode_sel, sof, req_valid, req_ready;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_data;
   logic          bram_we;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_din;
   logic [1:0]    grant, cam_live;
   logic [15:0]   drop_cnt0, drop_cnt1;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   fb_wr_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode_sel  (mode_sel),
      .sof       (sof),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .bram_we   (bram_we),
      .bram_addr (bram_addr),
      .bram_din  (bram_din),
      .grant     (grant),
      .cam_live  (cam_live),
      .drop_cnt0 (drop_cnt0),
      .drop_cnt1 (drop_cnt1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            t;
   } ent_t;

   ent_t          fq0[$];
   ent_t          fq1[$];
   int            cyc = 0;
   logic [1:0]    m_live = 2'b00;
   int            m_last = 1;
   logic          m_we = 1'b0;
   logic [1:0]    m_grant = 2'b00;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_din = '0;
   int            m_drop[2] = '{0, 0};

   int            sz[2];
   bit            el[2];
   bit            acc[2];
   logic [1:0]    nl;
   logic [AW-1:0] ra[2];
   logic [DW-1:0] rdat[2];
   int            g;
   ent_t          e;
   logic [31:0]   tsum;

   function automatic bit mode_bit(input logic [1:0] m, input int c);
      return (m == 2'b00) || (m == 2'b01 && c == 0) || (m == 2'b10 && c == 1);
   endfunction

   function automatic int exp_drop(input int c);
`ifdef FB_ARB_DROP_CNT_EN
      return m_drop[c];
`else
      return 0;
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fq0.delete();
         fq1.delete();
         m_live  = 2'b00;
         m_last  = 1;
         m_we    = 1'b0;
         m_grant = 2'b00;
         m_drop[0] = 0;
         m_drop[1] = 0;
      end else begin
         cyc++;
         sz[0] = fq0.size();
         sz[1] = fq1.size();
         el[0] = 0;
         el[1] = 0;
         if (sz[0] > 0) el[0] = (fq0[0].t <= cyc - 2);
         if (sz[1] > 0) el[1] = (fq1[0].t <= cyc - 2);
         for (int c = 0; c < 2; c++) begin
            nl[c]   = sof[c] ? mode_bit(mode_sel, c) : m_live[c];
            ra[c]   = req_addr[c*AW +: AW];
            rdat[c] = req_data[c*DW +: DW];
            acc[c]  = 0;
            if (req_valid[c] && nl[c]) begin
               if (sz[c] == 2 || int'(ra[c]) >= REGION) begin
                  if (m_drop[c] < 65535) m_drop[c]++;
               end else begin
                  acc[c] = 1;
               end
            end
         end
         if (el[0] && el[1])  g = (m_last == 0) ? 1 : 0;
         else if (el[0])      g = 0;
         else if (el[1])      g = 1;
         else                 g = -1;
         m_we    = 1'b0;
         m_grant = 2'b00;
         if (g == 0) begin
            e = fq0.pop_front();
            m_addr = e.a;
         end else if (g == 1) begin
            e = fq1.pop_front();
            tsum = 32'(e.a) + BASE1;
            m_addr = tsum[AW-1:0];
         end
         if (g >= 0) begin
            m_we    = 1'b1;
            m_grant = (g == 0) ? 2'b01 : 2'b10;
            m_din   = e.d;
            m_last  = g;
         end
         if (acc[0]) fq0.push_back('{a: ra[0], d: rdat[0], t: cyc});
         if (acc[1]) fq1.push_back('{a: ra[1], d: rdat[1], t: cyc});
         m_live = nl;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      chk("we", 32'(bram_we), 32'(m_we));
      chk("grant", 32'(grant), 32'(m_grant));
      chk("cam_live", 32'(cam_live), 32'(m_live));
      chk("req_ready", 32'(req_ready), {30'd0, fq1.size() != 2, fq0.size() != 2});
      if (m_we) begin
         chk("addr", 32'(bram_addr), 32'(m_addr));
         chk("din", 32'(bram_din), 32'(m_din));
      end
      chk("drop0", 32'(drop_cnt0), exp_drop(0));
      chk("drop1", 32'(drop_cnt1), exp_drop(1));
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0;
      sof = 2'b00;
      req_valid = 2'b00;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   int d0b, d1b;

   initial begin
      mode_sel  = 2'b00;
      sof       = 2'b00;
      req_valid = 2'b00;
      req_addr  = '0;
      req_data  = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_we", 32'(bram_we), 0);
      chk("rst_ready", 32'(req_ready), 32'h3);
      chk("rst_live", 32'(cam_live), 0);
      chk("rst_grant", 32'(grant), 0);
      tick();
      rst_n = 1'b1;

      // Single cam0 write: lands two edges after acceptance.
      mode_sel = 2'b00;
      sof = 2'b11;
      req_valid = 2'b01;
      req_addr[AW-1:0] = 20'd5;
      req_data[DW-1:0] = 12'hABC;
      tick();
      sof = 2'b00;
      req_valid = 2'b00;
      tick();
      @(negedge clk);
      chk("t1_we_early", 32'(bram_we), 0);
      tick();
      @(negedge clk);
      chk("t1_we", 32'(bram_we), 1);
      chk("t1_addr", 32'(bram_addr), 5);
      chk("t1_din", 32'(bram_din), 32'hABC);
      chk("t1_grant", 32'(grant), 1);
      chk("t1_live", 32'(cam_live), 32'h3);
      tick();
      @(negedge clk);
      chk("t1_we_off", 32'(bram_we), 0);

      // Sustained contention from reset: cam0 wins first, then alternate.
      do_reset();
      mode_sel = 2'b00;
      sof = 2'b11;
      req_valid = 2'b11;
      for (int k = 0; k < 12; k++) begin
         req_addr = {20'(k), 20'(100 + k)};
         req_data = {12'(12'h800 + k), 12'(12'h100 + k)};
         tick();
         sof = 2'b00;
         if (k == 2) begin
            @(negedge clk);
            chk("t2_g0", 32'(grant), 1);
            chk("t2_a0", 32'(bram_addr), 100);
         end
         if (k == 3) begin
            @(negedge clk);
            chk("t2_g1", 32'(grant), 2);
            chk("t2_a1", 32'(bram_addr), 76800);
            chk("t2_d1", 32'(bram_din), 32'h800);
         end
         if (k == 4) begin
            @(negedge clk);
            chk("t2_g2", 32'(grant), 1);
         end
      end
      req_valid = 2'b00;
      repeat (6) tick();

      // Mode change mid-frame: cam1 keeps writing until its own sof.
      mode_sel = 2'b01;
      req_valid = 2'b10;
      for (int k = 0; k < 4; k++) begin
         req_addr[2*AW-1:AW] = 20'(200 + k);
         tick();
      end
      @(negedge clk);
      chk("t3_live_hold", 32'(cam_live), 32'h3);
      d1b = exp_drop(1);
      sof = 2'b10;
      tick();
      sof = 2'b00;
      repeat (4) tick();
      req_valid = 2'b00;
      @(negedge clk);
      chk("t3_live", 32'(cam_live), 32'h1);
      chk("t3_drop1", 32'(drop_cnt1), d1b);
      tick();
      tick();

      // Out-of-range cam0 index.
      d0b = exp_drop(0);
      req_valid = 2'b01;
      req_addr[AW-1:0] = 20'd76800;
      tick();
      req_valid = 2'b00;
      tick();
      tick();
      @(negedge clk);
      chk("t4_we", 32'(bram_we), 0);
      chk("t4_drop0", 32'(drop_cnt0), d0b + DROP_INC);

      // Reset with both buffers full.
      mode_sel = 2'b00;
      sof = 2'b11;
      req_valid = 2'b11;
      req_addr = {20'd7, 20'd9};
      tick();
      sof = 2'b00;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("t5_we", 32'(bram_we), 0);
      chk("t5_grant", 32'(grant), 0);
      chk("t5_ready", 32'(req_ready), 32'h3);
      chk("t5_live", 32'(cam_live), 0);
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      @(negedge clk);
      chk("t5_nowrite", 32'(bram_we), 0);
      req_valid = 2'b00;

      // Randomized traffic.
      for (int k = 0; k < 4000; k++) begin
         sof = ($urandom_range(0, 99) < 4) ? 2'($urandom) : 2'b00;
         if ($urandom_range(0, 149) == 0) mode_sel = 2'($urandom);
         req_valid = 2'($urandom);
         for (int c = 0; c < 2; c++) begin
            if ($urandom_range(0, 99) < 6)
               req_addr[c*AW +: AW] = 20'($urandom_range(76800, 1048575));
            else
               req_addr[c*AW +: AW] = 20'($urandom_range(0, 76799));
            req_data[c*DW +: DW] = 12'($urandom);
         end
         tick();
      end
      req_valid = 2'b00;
      sof = 2'b00;
      repeat (5) tick();

`ifdef FB_ARB_DROP_CNT_EN
      // Counter saturation via continuous out-of-range requests.
      mode_sel = 2'b00;
      sof = 2'b11;
      req_valid = 2'b11;
      req_addr = {20'd80000, 20'd80000};
      tick();
      sof = 2'b00;
      repeat (70000) tick();
      req_valid = 2'b00;
      @(negedge clk);
      chk("t6_sat0", 32'(drop_cnt0), 32'hFFFF);
      chk("t6_sat1", 32'(drop_cnt1), 32'hFFFF);
`endif

      tick();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
